mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the MIPS CPU datapath. It owns the HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The single-cycle ALU produces combinational results; this block is its multi-cycle counterpart. The controller issues an operation with `start` and stalls on `busy`. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `XLEN`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored.
- `a`  in  32  rs operand (multiplicand/dividend; source value for MTHI/MTLO).
- `b`  in  32  rt operand (multiplier/divisor).
- `busy`  out  1  high while an arithmetic operation is in progress.
- `done`  out  1  one-cycle pulse when `hi`/`lo` have just been updated.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - `start`=1 with an arithmetic op: latch operand magnitudes. Signed ops take |a| and |b|; unsigned ops take raw values. Also latch the result sign flags. Clear the 6-bit iteration counter and go to RUN.
  - `start`=1 with MTHI/MTLO: write `a` to `hi`/`lo` at that edge, pulse `done`, stay in IDLE.
- RUN: 32 iterations, one bit per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract with a 33-bit partial remainder.
  - After iteration 31, go to FIX.
- FIX: apply signs, write `hi`/`lo`, pulse `done`, return to IDLE.
  - MULT: the 64-bit product is negated if sign(a)≠sign(b).
  - DIV: the quotient is negated if sign(a)≠sign(b); the remainder takes the sign of `a`.
- Results:
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero: lo=32'hFFFF_FFFF, hi=a, for both DIV and DIVU; latency is unchanged.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- `start` while `busy`=1 is ignored, with no queueing. `a`/`b`/`op` may change freely after the accepting edge.
- Invalid `op` codes: no state change and no `done`.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. An operation in flight is discarded.

## Timing
- Arithmetic op accepted at edge E0:
  - `busy`=1 from E0 through E33.
  - RUN occupies cycles E1..E32; FIX is E33.
  - `hi`/`lo` update and `done`=1 after E33. `busy`=0 in the same cycle as `done`.
  - Total latency is 34 edges.
- MTHI/MTLO accepted at E0: register updated and `done`=1 after E0. `busy` is never asserted.
- A new `start` is accepted in the same cycle `done` is high; back-to-back throughput is 34 cycles.
- `hi`/`lo` hold their values until the FIX edge, so MFHI during `busy` returns the previous result.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU supported as above.
- `MDU_DIV_EN` undefined:
  - Divider datapath and sign-fix logic for the remainder are removed.
  - DIV/DIVU are treated as invalid ops: ignored, no `busy`, no `done`, `hi`/`lo` unchanged.
  - Multiply and MTHI/MTLO behaviour is identical to the defined case.

## Structure
- Shared package `mdu_pkg`:
  - op encodings (`MDU_MULT`..`MDU_MTLO`)
  - state encoding (IDLE/RUN/FIX)
  - `MDU_ITER` = 32
- Sub-module `mdu_divstep`: combinational single-bit restoring step. Inputs: 33-bit remainder, dividend bit, divisor. Outputs: next remainder and quotient bit. Instantiated only under `MDU_DIV_EN`.
- The multiply step stays inline. HI/LO use async-clear flops.

## Test plan
- Reset then idle: `hi`=`lo`=0 and `busy`=`done`=0. Apply MTHI a=32'h1234_5678 → `hi`=32'h1234_5678 after one edge with a `done` pulse; `busy` stays 0.
- MULT a=32'hFFFF_FFFE (-2), b=3 → after 34 edges {hi,lo}=64'hFFFF_FFFF_FFFF_FFFA. MULTU with the same operands → hi=32'h0000_0002, lo=32'hFFFF_FFFA.
- DIV a=-7, b=2 → lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU a=100, b=7 → lo=14, hi=2. DIVU b=0 → lo=32'hFFFF_FFFF, hi=a.
- Edge operands:
  - DIV 32'h8000_0000 / -1 → lo=32'h8000_0000, hi=0.
  - MULT 32'h8000_0000 × 32'h8000_0000 → {hi,lo}=64'h4000_0000_0000_0000.
- Issue `start` with a new MULT at cycle 10 of a running DIV: it is ignored and the DIV result is unaffected. Then deassert `reset_n` at cycle 20 of a fresh MULT: `busy`, `hi` and `lo` go to 0 immediately and no `done` follows.
- Back-to-back: a second MULT raised in the `done` cycle is accepted. Its result appears 34 edges later, and MFHI before then still shows the first result.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and helpers for the iterative multiply/divide unit.
// Rev 1.0
`default_nettype none

package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'b000;
   localparam logic [2:0] MDU_MULTU = 3'b001;
   localparam logic [2:0] MDU_DIV   = 3'b010;
   localparam logic [2:0] MDU_DIVU  = 3'b011;
   localparam logic [2:0] MDU_MTHI  = 3'b100;
   localparam logic [2:0] MDU_MTLO  = 3'b101;

   localparam int MDU_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   // Magnitude of a two's-complement value when the op is signed, raw value otherwise.
   function automatic logic [31:0] mdu_abs(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? -x : x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step (shift in a dividend bit, trial subtract).
// Rev 1.0
`default_nettype none

module mdu_divstep (
   input  logic [32:0] rem_i,
   input  logic        dvd_bit_i,
   input  logic [31:0] dvsr_i,
   output logic [32:0] rem_o,
   output logic        q_o
);

   logic [33:0] shifted;
   logic [32:0] diff;

   always_comb begin
      shifted = {rem_i, dvd_bit_i};
      q_o     = (shifted >= {2'b00, dvsr_i});
      diff    = shifted[32:0] - {1'b0, dvsr_i};
      rem_o   = q_o ? diff : shifted[32:0];
   end

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// mdu: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, 34-edge latency.
// Rev 1.0 -- define MDU_DIV_EN to include the divider (DIV/DIVU are ignored otherwise).
`default_nettype none

module mdu
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   mdu_state_e  state_q;
   logic [5:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] opb_q;
   logic        neg_q;
   logic        busy_q, done_q;
   logic [31:0] hi_q, lo_q;

   logic        is_arith, signed_op;
   logic [32:0] mul_sum_d;
   logic [63:0] mul_acc_d, prod_fix_d;

`ifdef MDU_DIV_EN
   logic        is_div_q, nega_q, dz_q;
   logic [32:0] rem_q, rem_d;
   logic        qbit_d;

   // acc_q[31:0] holds the dividend shifting out MSB-first and the quotient shifting in.
   mdu_divstep u_divstep (
      .rem_i     (rem_q),
      .dvd_bit_i (acc_q[31]),
      .dvsr_i    (opb_q),
      .rem_o     (rem_d),
      .q_o       (qbit_d)
   );
`endif

   always_comb begin
`ifdef MDU_DIV_EN
      is_arith = (op_i == MDU_MULT) || (op_i == MDU_MULTU) ||
                 (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
`else
      is_arith = (op_i == MDU_MULT) || (op_i == MDU_MULTU);
`endif
      signed_op  = ~op_i[0];
      // Shift-add: upper half accumulates the multiplicand, multiplier retires from the LSB.
      mul_sum_d  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
      mul_acc_d  = {mul_sum_d, acc_q[31:1]};
      prod_fix_d = neg_q ? -acc_q : acc_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MDU_DIV_EN
         is_div_q <= 1'b0;
         nega_q   <= 1'b0;
         dz_q     <= 1'b0;
         rem_q    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i && is_arith) begin
                  acc_q   <= {32'd0, mdu_abs(a_i, signed_op)};
                  opb_q   <= mdu_abs(b_i, signed_op);
                  neg_q   <= signed_op & (a_i[31] ^ b_i[31]);
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
`ifdef MDU_DIV_EN
                  is_div_q <= op_i[1];
                  nega_q   <= signed_op & a_i[31];
                  dz_q     <= (b_i == 32'd0);
                  rem_q    <= '0;
`endif
               end else if (start_i && op_i == MDU_MTHI) begin
                  hi_q   <= a_i;
                  done_q <= 1'b1;
               end else if (start_i && op_i == MDU_MTLO) begin
                  lo_q   <= a_i;
                  done_q <= 1'b1;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q + 6'd1;
`ifdef MDU_DIV_EN
               if (is_div_q) begin
                  rem_q <= rem_d;
                  acc_q <= {acc_q[63:32], acc_q[30:0], qbit_d};
               end else begin
                  acc_q <= mul_acc_d;
               end
`else
               acc_q <= mul_acc_d;
`endif
               if (cnt_q == 6'(MDU_ITER - 1)) state_q <= ST_FIX;
            end
            ST_FIX: begin
`ifdef MDU_DIV_EN
               if (is_div_q) begin
                  // Divide-by-zero: the restoring loop already leaves |a| as remainder,
                  // so the remainder sign fix reproduces a; only the quotient is forced.
                  lo_q <= dz_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
                  hi_q <= nega_q ? -rem_q[31:0] : rem_q[31:0];
               end else begin
                  {hi_q, lo_q} <= prod_fix_d;
               end
`else
               {hi_q, lo_q} <= prod_fix_d;
`endif
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for mdu against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_mdu;
   import mdu_pkg::*;

   logic        clk, reset_n, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] hi_m = 0, lo_m = 0;

   mdu #(.XLEN(32)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .start_i   (start),
      .op_i      (op),
      .a_i       (a),
      .b_i       (b),
      .busy_o    (busy),
      .done_o    (done),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_arith(input logic [2:0] o);
`ifdef MDU_DIV_EN
      return (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
`else
      return (o == MDU_MULT) || (o == MDU_MULTU);
`endif
   endfunction

   // Reference result {hi,lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      if (o == MDU_MULT)  return sx * sy;
      if (o == MDU_MULTU) return ux * uy;
      if (y == 32'd0)     return {x, 32'hFFFF_FFFF};
      if (o == MDU_DIV) begin
         q = sx / sy;
         r = sx % sy;
         return {r[31:0], q[31:0]};
      end
      return {x % y, x / y};
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int          cyc;
      logic [63:0] exp;
      issue(o, x, y);
      if (model_arith(o)) begin
         chk($sformatf("busy_accept op%0d", o), busy, 1);
         chk($sformatf("hilo_hold op%0d", o), {hi, lo}, {hi_m, lo_m});
         wait_done(cyc);
         chk($sformatf("latency op%0d", o), cyc, 33);
         exp  = model(o, x, y);
         hi_m = exp[63:32];
         lo_m = exp[31:0];
         chk($sformatf("result op%0d a=%h b=%h", o, x, y), {hi, lo}, exp);
         chk($sformatf("busy_done op%0d", o), busy, 0);
      end else if (o == MDU_MTHI || o == MDU_MTLO) begin
         if (o == MDU_MTHI) hi_m = x;
         else               lo_m = x;
         chk($sformatf("mt_done op%0d", o), done, 1);
         chk($sformatf("mt_busy op%0d", o), busy, 0);
         chk($sformatf("mt_hilo op%0d", o), {hi, lo}, {hi_m, lo_m});
      end else begin
         chk($sformatf("ign_done op%0d", o), done, 0);
         chk($sformatf("ign_busy op%0d", o), busy, 0);
         chk($sformatf("ign_hilo op%0d", o), {hi, lo}, {hi_m, lo_m});
      end
   endtask

   initial begin
      int          cyc, seen;
      logic [2:0]  first_op, ro;
      logic [31:0] rx, ry;
      logic [63:0] exp;
`ifdef MDU_DIV_EN
      first_op = MDU_DIV;
`else
      first_op = MDU_MULT;
`endif
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      a       = 32'd0;
      b       = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {busy, done, hi, lo}, 66'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_state", {busy, done, hi, lo}, 66'd0);

      // Directed cases.
      do_op(MDU_MTHI,  32'h1234_5678, 32'd0);
      do_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3);
      do_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
      do_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
      do_op(MDU_DIVU,  32'd100,       32'd7);
      do_op(MDU_DIVU,  32'hDEAD_BEEF, 32'd0);
      do_op(MDU_DIV,   32'h8765_4321, 32'd0);
      do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      do_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000);
      do_op(3'b110,    32'h1111_1111, 32'd5);
      do_op(3'b111,    32'h2222_2222, 32'd5);

      // Start during a running op must be ignored.
      issue(first_op, 32'hFFFF_FF9C, 32'd7);
      repeat (9) @(posedge clk);
      issue(MDU_MULT, 32'd5, 32'd6);
      wait_done(cyc);
      chk("midstart_latency", cyc, 23);
      exp  = model(first_op, 32'hFFFF_FF9C, 32'd7);
      hi_m = exp[63:32];
      lo_m = exp[31:0];
      chk("midstart_result", {hi, lo}, exp);

      // Randomized mix; consecutive arithmetic ops are issued in the done cycle.
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 9))
            0:       ry = 32'd0;
            1:       ry = 32'hFFFF_FFFF;
            2:       ry = $urandom_range(1, 15);
            default: ry = $urandom;
         endcase
         do_op(ro, rx, ry);
      end

      // Asynchronous reset in the middle of a multiply.
      do_op(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
      issue(MDU_MULT, 32'd12345, 32'd678);
      repeat (19) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_async", {busy, done, hi, lo}, 66'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      chk("rst_no_done", seen, 0);
      chk("rst_hilo", {busy, hi, lo}, 65'd0);
      do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
